// File: rtl/countdown_timer.sv
// Programmable down-counting timer with pause/resume and optional auto-reload.
// Loads a (saturated) value, decrements once per clock while running, and
// pulses expired for one cycle on the edge where the count reaches zero.
module countdown_timer #(
    parameter int unsigned              DATA_WIDTH = 16,
    parameter logic [DATA_WIDTH-1:0]    MAX_LOAD   = '1
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    load,
    input  logic [DATA_WIDTH-1:0]   load_value,
    input  logic                    start,
    input  logic                    stop,
    input  logic                    auto_reload,
    output logic [DATA_WIDTH-1:0]   count,
    output logic                    running,
    output logic                    expired
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        PAUSED = 2'd2
    } state_t;

    state_t                 state;
    logic [DATA_WIDTH-1:0]  reload_reg;
    logic [DATA_WIDTH-1:0]  load_sat_c;
    logic                   dec_en_c;

    // Clamp the requested load value to the largest accepted value
    always_comb begin
        load_sat_c = load_value;
        if (load_value > MAX_LOAD) begin
            load_sat_c = MAX_LOAD;
        end
    end

    // Decrement on this edge: already running, or a start from IDLE/PAUSED with a nonzero count
    always_comb begin
        dec_en_c = 1'b0;
        if (!load && !stop) begin
            if (state == RUN) begin
                dec_en_c = 1'b1;
            end else if (start && (count != '0)) begin
                dec_en_c = 1'b1;
            end
        end
    end

    // Timer state machine: priority is load > stop > start > decrement
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= IDLE;
            count      <= '0;
            reload_reg <= '0;
            running    <= 1'b0;
            expired    <= 1'b0;
        end else begin
            expired <= 1'b0;
            if (load) begin
                count      <= load_sat_c;
                reload_reg <= load_sat_c;
                state      <= IDLE;
                running    <= 1'b0;
            end else if (stop) begin
                if (state == RUN) begin
                    state   <= PAUSED;
                    running <= 1'b0;
                end
            end else if (dec_en_c) begin
                if (count == DATA_WIDTH'(1)) begin
                    // Terminal edge: either restart the period or fall back to idle
                    expired <= 1'b1;
                    if (auto_reload) begin
                        count   <= reload_reg;
                        state   <= RUN;
                        running <= 1'b1;
                    end else begin
                        count   <= '0;
                        state   <= IDLE;
                        running <= 1'b0;
                    end
                end else if (count == '0) begin
                    // Never decrement from zero; a zero count cannot keep running
                    state   <= IDLE;
                    running <= 1'b0;
                end else begin
                    count   <= count - DATA_WIDTH'(1);
                    state   <= RUN;
                    running <= 1'b1;
                end
            end
        end
    end

endmodule

// File: doc/countdown_timer.md
Name: countdown_timer

Overview:
Programmable down-counting timer, the counterpart to the team's up-counting stopwatch. Software or a controller loads a value, starts the count, and can pause and resume it. The block decrements once per clock and raises a one-cycle expired pulse when the count reaches zero. In auto-reload mode it optionally restarts from the loaded value, acting as a periodic tick generator for downstream control logic.

Parameters:
DATA_WIDTH, 16, width of count, load value and reload register
MAX_LOAD, 2**DATA_WIDTH-1, largest accepted load value; load_value above MAX_LOAD is saturated to MAX_LOAD

Ports:
clk  input  1  single clock; all state updates on its rising edge
resetn  input  1  asynchronous, active-low reset
load  input  1  capture load_value into count and reload register
load_value  input  DATA_WIDTH  value to load
start  input  1  begin or resume counting
stop  input  1  pause counting
auto_reload  input  1  on expiry, reload and keep running (sampled at the expiry edge)
count  output  DATA_WIDTH  current remaining count
running  output  1  high while state is RUN
expired  output  1  one-cycle pulse coincident with the expiry update

Behaviour:
- One clock, clk. Reset resetn is asynchronous and active-low.
- Reset (resetn=0, asynchronous) forces:
  - count=0, reload_reg=0, state=IDLE
  - running=0, expired=0
- All outputs are registered. running == (state==RUN).
- FSM states: IDLE, RUN, PAUSED.
- Per-edge priority: load > stop > start > normal decrement.
- load, any state:
  - count <= sat(load_value) and reload_reg <= sat(load_value)
  - state <= IDLE
  - expired <= 0
  - the same-cycle start/stop is ignored.
- stop:
  - In RUN: state <= PAUSED and count holds. No decrement on that edge.
  - In IDLE or PAUSED: no effect.
  - start and stop in the same cycle: stop wins, start is ignored.
- start, in IDLE or PAUSED:
  - count != 0: state <= RUN, and that same edge performs the first decrement (zero-latency start).
  - count == 0: ignored; state stays put and expired stays 0.
  - start while already in RUN: no effect (no restart).
- RUN, no load/stop: every edge count <= count-1.
- Terminal edge (count==1 at the decrementing edge, including a start edge):
  - expired <= 1 for exactly one cycle.
  - auto_reload=1: count <= reload_reg and state stays RUN. Period = reload_reg cycles between expired pulses.
  - auto_reload=0: count <= 0 and state <= IDLE.
- count never decrements from 0. There is no wrap to all-ones.
- expired is 0 on every edge except a terminal edge.
- auto_reload may change at any time; only its value at the terminal edge matters.
- Reset mid-RUN: immediate return to reset values. After reset deassertion, state is IDLE and start is ignored until a nonzero load.
- Arithmetic is unsigned DATA_WIDTH. The reload register keeps the last loaded value across expiries and pauses.

Test Plan:
- Reset and idle: assert resetn=0 mid-count, then release, then pulse start with no load -> count=0, running=0, expired never asserted.
- One-shot: load 5, then start at cycle T -> count 4,3,2,1,0 at T+1..T+5; expired high only at T+5; running=0 from T+5 onward.
- Pause/resume: load 10, start; stop when count=6; hold 4 cycles; start again -> count stays 6 while paused, then 5,4,...; expired occurs after 6 further run edges.
- Auto-reload: load 3, auto_reload=1, start -> count sequence 2,1,3,2,1,3,...; expired pulses every 3 cycles; running stays 1. Drop auto_reload before the next terminal edge -> count goes to 0 and state goes to IDLE.
- Priority collisions:
  - start+stop together in PAUSED -> stays PAUSED.
  - load 7 together with start in RUN -> count=7, state IDLE, no decrement.
  - load with load_value=0 then start -> ignored, expired=0.
- Boundary: DATA_WIDTH=4, load 15 (MAX_LOAD), start -> 15 decrements to 0; expired once; count never shows 15 after the start edge and never wraps.
